digitally_controlled_oscillator: RTL and testbench

DIGITALLY_CONTROLLED_OSCILLATOR -- requirements
Module: digitally_controlled_oscillator

---
 rtl/adpll_pkg.sv | 14 +
 rtl/dco_period_clamp.sv | 30 +++
 rtl/digitally_controlled_oscillator.sv | 86 ++++++++
 tb/tb_digitally_controlled_oscillator.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/adpll_pkg.sv
// adpll_pkg: shared oscillator state encoding and clamp arithmetic width helper
package adpll_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } dco_state_e;

  function automatic int clamp_width(input int w, input int pw);
    return (w > pw ? w : pw) + 2;
  endfunction

endpackage

// File: rtl/dco_period_clamp.sv
// dco_period_clamp: half-period = clamp(nominal - ctrl) with a saturation flag
module dco_period_clamp
  import adpll_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int PERIOD_WIDTH = 16,
  parameter int MIN_HALF     = 2,
  parameter int MAX_HALF     = 2**PERIOD_WIDTH-1
) (
  input  logic signed [WIDTH-1:0]        ctrl_i,
  input  logic        [PERIOD_WIDTH-1:0] nominal_i,
  output logic        [PERIOD_WIDTH-1:0] half_o,
  output logic                           sat_o
);

  localparam int CW = clamp_width(WIDTH, PERIOD_WIDTH);
  localparam logic signed [CW-1:0] MIN_S = CW'(MIN_HALF);
  localparam logic signed [CW-1:0] MAX_S = CW'(MAX_HALF);

  logic signed [CW-1:0] diff;
  logic lo, hi;

  // two guard bits above the wider operand keep the subtraction exact
  assign diff   = $signed(CW'(nominal_i)) - CW'(ctrl_i);
  assign lo     = diff < MIN_S;
  assign hi     = diff > MAX_S;
  assign sat_o  = lo | hi;
  assign half_o = lo ? PERIOD_WIDTH'(MIN_HALF) : hi ? PERIOD_WIDTH'(MAX_HALF) : diff[PERIOD_WIDTH-1:0];

endmodule

// File: rtl/digitally_controlled_oscillator.sv
// digitally_controlled_oscillator: square wave whose half-period is nominal minus a clamped correction
module digitally_controlled_oscillator
  import adpll_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int PERIOD_WIDTH = 16,
  parameter int NOMINAL_HALF = 500,
  parameter int MIN_HALF     = 2,
  parameter int MAX_HALF     = 2**PERIOD_WIDTH-1
) (
  input  logic                           fpga_clk_i,
  input  logic                           reset_i,
  input  logic                           enable_i,
  input  logic signed [WIDTH-1:0]        ctrl_i,
  input  logic                           ctrl_valid_i,
  output logic                           generated_o,
  output logic                           edge_o,
  output logic        [PERIOD_WIDTH-1:0] half_period_o,
  output logic                           sat_o
);

  localparam logic [PERIOD_WIDTH-1:0] NOM = PERIOD_WIDTH'(NOMINAL_HALF);

  dco_state_e              state_q;
  logic [PERIOD_WIDTH-1:0] cnt_q, half_q, pend_half_q, clamp_half;
  logic                    gen_q, edge_q, sat_q, pend_sat_q, clamp_sat, bnd;

  dco_period_clamp #(
    .WIDTH       (WIDTH),
    .PERIOD_WIDTH(PERIOD_WIDTH),
    .MIN_HALF    (MIN_HALF),
    .MAX_HALF    (MAX_HALF)
  ) u_clamp (
    .ctrl_i   (ctrl_i),
    .nominal_i(NOM),
    .half_o   (clamp_half),
    .sat_o    (clamp_sat)
  );

  assign bnd = cnt_q == half_q - 1'b1;

  // oscillator FSM; a strobe only touches the pending value, phases load it at their boundary
  always_ff @(posedge fpga_clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      gen_q       <= 1'b0;
      edge_q      <= 1'b0;
      half_q      <= NOM;
      sat_q       <= 1'b0;
      pend_half_q <= NOM;
      pend_sat_q  <= 1'b0;
    end else begin
      edge_q <= 1'b0;
      if (ctrl_valid_i) begin
        pend_half_q <= clamp_half;
        pend_sat_q  <= clamp_sat;
      end
      case (state_q)
        IDLE: if (enable_i) begin
          state_q <= HIGH;
          cnt_q   <= '0;
          gen_q   <= 1'b1;
          edge_q  <= 1'b1;
        end
        HIGH, LOW: if (bnd) begin
          state_q <= state_q == HIGH ? LOW : enable_i ? HIGH : IDLE;
          gen_q   <= state_q == LOW && enable_i;
          edge_q  <= state_q == LOW && enable_i;
          cnt_q   <= '0;
          half_q  <= pend_half_q;
          sat_q   <= pend_sat_q;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign generated_o   = gen_q;
  assign edge_o        = edge_q;
  assign half_period_o = half_q;
  assign sat_o         = sat_q;

endmodule

// File: tb/tb_digitally_controlled_oscillator.sv
// tb_digitally_controlled_oscillator: directed scoreboard bench checking phase lengths, half-period and saturation
module tb_digitally_controlled_oscillator;

  logic              clk = 1'b0;
  logic              reset_i = 1'b1;
  logic              enable_i = 1'b0;
  logic signed [7:0] ctrl_i = '0;
  logic              ctrl_valid_i = 1'b0;
  logic              generated_o, edge_o, sat_o;
  logic [15:0]       half_period_o;

  digitally_controlled_oscillator #(
    .WIDTH(8), .PERIOD_WIDTH(16), .NOMINAL_HALF(5), .MIN_HALF(2), .MAX_HALF(8)
  ) dut (
    .fpga_clk_i   (clk),
    .reset_i      (reset_i),
    .enable_i     (enable_i),
    .ctrl_i       (ctrl_i),
    .ctrl_valid_i (ctrl_valid_i),
    .generated_o  (generated_o),
    .edge_o       (edge_o),
    .half_period_o(half_period_o),
    .sat_o        (sat_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          len;
    logic [15:0] half;
    logic        sat;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   failures = 0;
  int   now = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // a run length of 0 means the length of that run is not constrained
  task automatic push(input int len, input int half, input logic sat);
    exp_t e;
    e.len  = len;
    e.half = 16'(half);
    e.sat  = sat;
    sbq.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic at(input int k);
    step(k - now);
    now = k;
  endtask

  task automatic strobe(input int k, input logic signed [7:0] v);
    at(k);
    ctrl_i = v;
    ctrl_valid_i = 1'b1;
    at(k + 1);
    ctrl_valid_i = 1'b0;
  endtask

  // monitor: every level change of generated_o closes a run and is scored against the queue
  initial begin
    logic prev = 1'b0;
    int   len = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      chk("edge_o", 32'(edge_o), 32'(generated_o && !prev));
      if (generated_o === prev) begin
        len++;
      end else begin
        if (sbq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_transition: got level %0d after run %0d expected none at %0t", generated_o, len, $time);
        end else begin
          e = sbq.pop_front();
          if (e.len != 0) chk(prev ? "high_len" : "low_len", 32'(len), 32'(e.len));
          chk("half_period_o", 32'(half_period_o), 32'(e.half));
          chk("sat_o", 32'(sat_o), 32'(e.sat));
        end
        len = 1;
      end
      prev = generated_o;
    end
  end

  initial begin
    int wait_cycles = 0;
    step(3);
    chk("rst_generated_o", 32'(generated_o), 32'd0);
    chk("rst_edge_o", 32'(edge_o), 32'd0);
    chk("rst_half_period_o", 32'(half_period_o), 32'd5);
    chk("rst_sat_o", 32'(sat_o), 32'd0);
    // nominal run: 5 high / 5 low
    push(0, 5, 0); push(5, 5, 0); push(5, 5, 0); push(5, 5, 0); push(5, 5, 0);
    reset_i = 1'b0;
    enable_i = 1'b1;
    step(1);
    now = 0;
    // +2 mid-high: current high stays 5, then 3-cycle phases
    push(5, 3, 0); push(3, 3, 0); push(3, 3, 0); push(3, 3, 0);
    strobe(22, 8'sd2);
    // saturation both ways, then back to nominal
    push(3, 8, 1); push(8, 8, 1); push(8, 2, 1); push(2, 2, 1); push(2, 8, 1); push(8, 5, 0); push(5, 5, 0);
    strobe(35, -8'sd100);
    strobe(46, 8'sd127);
    strobe(55, -8'sd128);
    strobe(58, 8'sd0);
    // +1 exactly on a boundary: next phase 5, then 4
    push(5, 5, 0); push(5, 4, 0); push(4, 4, 0); push(4, 4, 0); push(4, 5, 0);
    strobe(74, 8'sd1);
    strobe(89, 8'sd0);
    // enable dropped in high: full high + low, idle, then restart
    push(5, 5, 0); push(14, 5, 0);
    at(94);
    enable_i = 1'b0;
    at(110);
    enable_i = 1'b1;
    // reset on cycle 3 of high discards the pending +2
    push(3, 5, 0); push(3, 5, 0); push(5, 5, 0); push(5, 5, 0); push(5, 5, 0);
    strobe(112, 8'sd2);
    reset_i = 1'b1;
    enable_i = 1'b0;
    at(114);
    reset_i = 1'b0;
    at(116);
    enable_i = 1'b1;
    at(127);
    enable_i = 1'b0;
    at(150);
    while (sbq.size() != 0 && wait_cycles < 200) begin
      step(1);
      wait_cycles++;
    end
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    chk("idle_generated_o", 32'(generated_o), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
